// File: rtl/spi0_master_pkg.sv
// Shared register map, CTRL/STAT bit positions and FSM encoding for the SPI0 master.
package spi0_master_pkg;
    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STAT   = 8'h04;
    localparam logic [7:0] REG_TXDATA = 8'h08;
    localparam logic [7:0] REG_RXDATA = 8'h0C;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CPOL    = 1;
    localparam int CTRL_CPHA    = 2;
    localparam int CTRL_CSMAN   = 3;
    localparam int CTRL_CSVAL   = 4;
    localparam int CTRL_IE      = 5;
    localparam int CTRL_DIV_LSB = 8;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_RXV   = 2;
    localparam int STAT_TXOVR = 3;
    localparam int STAT_RXOVR = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_e;
endpackage

// File: rtl/spi0_master_shift_core.sv
// SPI transfer engine: FSM, half-period and toggle counters, shift registers, SCK/MOSI/CS.
// One transfer occupies LEAD + 16 half periods + TRAIL; abort_i returns to IDLE next cycle.
module spi_shift_core
    import spi0_master_pkg::*;
#(
    parameter int DIV_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [DIV_W-1:0]  clkdiv_i,
    input  logic [DATA_W-1:0] tx_i,
    input  logic              miso_i,
    output logic              busy_o,
    output logic              fin_o,
    output logic [DATA_W-1:0] rx_o,
    output logic              sck_o,
    output logic              mosi_o,
    output logic              cs_o
);
    localparam int TW = $clog2(2 * DATA_W);
    localparam logic [TW-1:0] TOG_LAST = TW'(2 * DATA_W - 1);

    spi_state_e        state_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  div_q;
    logic [TW-1:0]     tog_q;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] rx_q;
    logic              sck_q;
    logic              mosi_q;
    logic              cs_q;
    logic              cpha_q;
    logic              half_end;
    logic              odd_tog;

    assign half_end = (cnt_q == div_q);
    // tog_q counts completed toggles, so the toggle being made now is number tog_q+1
    assign odd_tog  = ~tog_q[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            tog_q   <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            cpha_q  <= 1'b0;
        end else if (abort_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tog_q   <= '0;
            cs_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_LEAD;
                        cnt_q   <= '0;
                        tog_q   <= '0;
                        sh_q    <= tx_i;
                        sck_q   <= cpol_i;
                        cs_q    <= 1'b0;
                        cpha_q  <= cpha_i;
                        div_q   <= clkdiv_i;
                        if (!cpha_i) mosi_q <= tx_i[DATA_W-1];
                    end
                end
                ST_LEAD: begin
                    if (half_end) begin
                        cnt_q   <= '0;
                        state_q <= ST_XFER;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                ST_XFER: begin
                    if (half_end) begin
                        cnt_q <= '0;
                        sck_q <= ~sck_q;
                        tog_q <= tog_q + TW'(1);
                        if (odd_tog == ~cpha_q) begin
                            rx_q <= {rx_q[DATA_W-2:0], miso_i};
                        end else if (cpha_q || tog_q != TOG_LAST) begin
                            // CPHA=0 already presented bit7 in LEAD, so it shifts out the next bit
                            mosi_o_sel : begin
                                mosi_q <= cpha_q ? sh_q[DATA_W-1] : sh_q[DATA_W-2];
                                sh_q   <= sh_q << 1;
                            end
                        end
                        if (tog_q == TOG_LAST) state_q <= ST_TRAIL;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                ST_TRAIL: begin
                    if (half_end) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        cs_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign fin_o  = (state_q == ST_TRAIL) && half_end && !abort_i;
    assign rx_o   = rx_q;
    assign sck_o  = (state_q == ST_IDLE) ? cpol_i : sck_q;
    assign mosi_o = mosi_q;
    assign cs_o   = cs_q;
endmodule

// File: rtl/spi0_master.sv
// SPI0 master bus block: CTRL/STAT/TXDATA/RXDATA registers, status flags and interrupt.
// Reads return registered data one edge after rd_i; TXDATA writes while busy or disabled are dropped.
module spi0_master
    import spi0_master_pkg::*;
#(
    parameter int DIV_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic [7:0]  raddr_i,
    input  logic        rd_i,
    output logic [31:0] data_o,
    output logic        SPI0_SCK,
    output logic        SPI0_MOSI,
    input  logic        SPI0_MISO,
    output logic        SPI0_CS,
    output logic        irq_spi0
);
    logic              en_q, cpol_q, cpha_q, csman_q, csval_q, ie_q;
    logic [DIV_W-1:0]  div_q;
    logic              done_q, rxv_q, txovr_q, rxovr_q;
    logic [DATA_W-1:0] rxdata_q;
    logic [31:0]       data_q;
    logic [31:0]       rdata_d;
    logic              wr, ctrl_wr, stat_wr, tx_wr, rx_rd;
    logic              en_d, start, busy, fin, core_cs;
    logic [DATA_W-1:0] rx_w;
    logic              unused_data;

    assign wr      = we_i && (sel_i == 4'hf);
    assign ctrl_wr = wr && (waddr_i == REG_CTRL);
    assign stat_wr = wr && (waddr_i == REG_STAT);
    assign tx_wr   = wr && (waddr_i == REG_TXDATA);
    assign rx_rd   = rd_i && (raddr_i == REG_RXDATA);
    // Abort looks at the incoming EN so the transfer stops the cycle after EN is cleared
    assign en_d    = ctrl_wr ? data_i[CTRL_EN] : en_q;
    assign start   = tx_wr && en_q && !busy;
    assign unused_data = ^data_i[31:CTRL_DIV_LSB+DIV_W];

    spi_shift_core #(.DIV_W(DIV_W), .DATA_W(DATA_W)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .abort_i  (!en_d),
        .cpol_i   (cpol_q),
        .cpha_i   (cpha_q),
        .clkdiv_i (div_q),
        .tx_i     (data_i[DATA_W-1:0]),
        .miso_i   (SPI0_MISO),
        .busy_o   (busy),
        .fin_o    (fin),
        .rx_o     (rx_w),
        .sck_o    (SPI0_SCK),
        .mosi_o   (SPI0_MOSI),
        .cs_o     (core_cs)
    );

    always_comb begin
        rdata_d = '0;
        case (raddr_i)
            REG_CTRL: begin
                rdata_d[CTRL_EN]                  = en_q;
                rdata_d[CTRL_CPOL]                = cpol_q;
                rdata_d[CTRL_CPHA]                = cpha_q;
                rdata_d[CTRL_CSMAN]               = csman_q;
                rdata_d[CTRL_CSVAL]               = csval_q;
                rdata_d[CTRL_IE]                  = ie_q;
                rdata_d[CTRL_DIV_LSB +: DIV_W]    = div_q;
            end
            REG_STAT: begin
                rdata_d[STAT_BUSY]  = busy;
                rdata_d[STAT_DONE]  = done_q;
                rdata_d[STAT_RXV]   = rxv_q;
                rdata_d[STAT_TXOVR] = txovr_q;
                rdata_d[STAT_RXOVR] = rxovr_q;
            end
            REG_RXDATA: rdata_d[DATA_W-1:0] = rxdata_q;
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {en_q, cpol_q, cpha_q, csman_q, csval_q, ie_q} <= '0;
            div_q    <= '0;
            done_q   <= 1'b0;
            rxv_q    <= 1'b0;
            txovr_q  <= 1'b0;
            rxovr_q  <= 1'b0;
            rxdata_q <= '0;
            data_q   <= '0;
        end else begin
            if (ctrl_wr) begin
                en_q    <= data_i[CTRL_EN];
                csman_q <= data_i[CTRL_CSMAN];
                csval_q <= data_i[CTRL_CSVAL];
                ie_q    <= data_i[CTRL_IE];
                // Timing fields are frozen while a transfer is running
                if (!busy) begin
                    cpol_q <= data_i[CTRL_CPOL];
                    cpha_q <= data_i[CTRL_CPHA];
                    div_q  <= data_i[CTRL_DIV_LSB +: DIV_W];
                end
            end
            if (fin)                               done_q <= 1'b1;
            else if (stat_wr && data_i[STAT_DONE]) done_q <= 1'b0;
            if (fin)        rxv_q <= 1'b1;
            else if (rx_rd) rxv_q <= 1'b0;
            if (fin) rxdata_q <= rx_w;
            if (tx_wr && !start)                    txovr_q <= 1'b1;
            else if (stat_wr && data_i[STAT_TXOVR]) txovr_q <= 1'b0;
            if (fin && rxv_q)                       rxovr_q <= 1'b1;
            else if (stat_wr && data_i[STAT_RXOVR]) rxovr_q <= 1'b0;
            if (rd_i) data_q <= rdata_d;
        end
    end

    assign data_o   = data_q;
    assign SPI0_CS  = csman_q ? csval_q : core_cs;
    assign irq_spi0 = done_q & ie_q;
endmodule

// File: tb/tb_spi0_master.sv
// Directed bench for spi0_master: loopback/slave-model transfers checked through a byte scoreboard.
module tb_spi0_master;
    import spi0_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  waddr_i, raddr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        we_i, rd_i;
    logic [31:0] data_o;
    logic        SPI0_SCK, SPI0_MOSI, SPI0_MISO, SPI0_CS, irq_spi0;

    logic        loop_en = 1'b1;
    logic [7:0]  slv_byte = 8'h00;
    logic        slv_miso = 1'b0;
    int          slv_idx = 0;

    int          n_chk = 0, n_pass = 0, n_fail = 0;
    int          busy_n, rises, edges, hp, hp_min, hp_max, cs_rises;
    logic [7:0]  cap;
    logic [7:0]  exp_q[$];
    logic [31:0] rd_val;

    always #5 clk = ~clk;

    assign SPI0_MISO = loop_en ? SPI0_MOSI : slv_miso;

    spi0_master dut (
        .clk(clk), .rst_n(rst_n), .waddr_i(waddr_i), .data_i(data_i), .sel_i(sel_i),
        .we_i(we_i), .raddr_i(raddr_i), .rd_i(rd_i), .data_o(data_o),
        .SPI0_SCK(SPI0_SCK), .SPI0_MOSI(SPI0_MOSI), .SPI0_MISO(SPI0_MISO),
        .SPI0_CS(SPI0_CS), .irq_spi0(irq_spi0)
    );

    // CPHA=1 slave: presents the next bit on each leading (falling, CPOL=1) SCK edge
    always @(negedge SPI0_SCK or posedge SPI0_CS) begin
        if (SPI0_CS) slv_idx = 0;
        else if (slv_idx < 8) begin
            slv_miso = slv_byte[7 - slv_idx];
            slv_idx++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk); waddr_i = a; data_i = d; we_i = 1'b1;
        @(negedge clk); we_i = 1'b0;
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk); raddr_i = a; rd_i = 1'b1;
        @(negedge clk); rd_i = 1'b0; d = data_o;
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] d, e;
        rd_reg(REG_RXDATA, d);
        e = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'hFFFF_FFFF;
        chk(tag, d, e);
    endtask

    // Starts a transfer, polls STAT every cycle and profiles SCK/MOSI/CS until BUSY drops.
    task automatic run_xfer(input logic [7:0] tx, input int ovr_at);
        logic sck_p, cs_p;
        wr_reg(REG_TXDATA, {24'h0, tx});
        raddr_i = REG_STAT; rd_i = 1'b1;
        busy_n = 0; rises = 0; edges = 0; hp = 0; hp_min = 1000; hp_max = 0; cs_rises = 0; cap = '0;
        sck_p = SPI0_SCK; cs_p = SPI0_CS;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == ovr_at) begin
                waddr_i = REG_TXDATA; data_i = 32'h0000_00FF; we_i = 1'b1;
            end else we_i = 1'b0;
            hp++;
            if (SPI0_SCK !== sck_p) begin
                if (edges > 0) begin
                    if (hp < hp_min) hp_min = hp;
                    if (hp > hp_max) hp_max = hp;
                end
                if (SPI0_SCK && !SPI0_CS) begin
                    rises++;
                    cap = {cap[6:0], SPI0_MOSI};
                end
                edges++; hp = 0; sck_p = SPI0_SCK;
            end
            if (SPI0_CS && !cs_p) cs_rises++;
            cs_p = SPI0_CS;
            if (data_o[STAT_BUSY]) busy_n++;
            else if (busy_n > 0) break;
        end
        we_i = 1'b0; rd_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; waddr_i = '0; raddr_i = '0; data_i = '0; sel_i = 4'hf; we_i = 1'b0; rd_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sck", 32'(SPI0_SCK), 32'd0);
        chk("rst_cs", 32'(SPI0_CS), 32'd1);
        chk("rst_mosi", 32'(SPI0_MOSI), 32'd0);
        chk("rst_irq", 32'(irq_spi0), 32'd0);
        chk("rst_data_o", data_o, 32'd0);
        rst_n = 1'b1;
        rd_reg(REG_STAT, rd_val);   chk("rst_stat", rd_val, 32'd0);
        rd_reg(REG_CTRL, rd_val);   chk("rst_ctrl", rd_val, 32'd0);

        // Mode 0, CLKDIV=0, loopback, IE=1
        wr_reg(REG_CTRL, 32'h0000_0021);
        rd_reg(REG_CTRL, rd_val);   chk("m0_ctrl_rb", rd_val, 32'h21);
        loop_en = 1'b1;
        exp_q.push_back(8'hA5);
        run_xfer(8'hA5, -1);
        chk("m0_busy_cycles", 32'(busy_n), 32'd18);
        chk("m0_sck_rises", 32'(rises), 32'd8);
        chk("m0_mosi_bits", 32'(cap), 32'hA5);
        chk("m0_half_period_max", 32'(hp_max), 32'd1);
        chk("m0_half_period_min", 32'(hp_min), 32'd1);
        chk("m0_irq", 32'(irq_spi0), 32'd1);
        rd_reg(REG_STAT, rd_val);   chk("m0_stat_done_rxv", rd_val, 32'h06);
        check_rx("m0_rxdata");
        rd_reg(REG_STAT, rd_val);   chk("m0_rxv_cleared", rd_val, 32'h02);
        wr_reg(REG_STAT, 32'h02);
        chk("m0_irq_after_w1c", 32'(irq_spi0), 32'd0);

        // Mode 3, CLKDIV=3, slave returns 0x3C
        wr_reg(REG_CTRL, 32'h0000_0307);
        chk("m3_sck_idle_high", 32'(SPI0_SCK), 32'd1);
        loop_en = 1'b0; slv_byte = 8'h3C;
        exp_q.push_back(8'h3C);
        run_xfer(8'h96, -1);
        chk("m3_busy_cycles", 32'(busy_n), 32'd72);
        chk("m3_sck_edges", 32'(edges), 32'd16);
        chk("m3_half_period_max", 32'(hp_max), 32'd4);
        chk("m3_half_period_min", 32'(hp_min), 32'd4);
        chk("m3_mosi_bits", 32'(cap), 32'h96);
        chk("m3_sck_end_high", 32'(SPI0_SCK), 32'd1);
        check_rx("m3_rxdata");

        // TXDATA overrun during a transfer, then RX overrun
        wr_reg(REG_CTRL, 32'h0000_0001);
        loop_en = 1'b1;
        wr_reg(REG_STAT, 32'h1A);
        rd_reg(REG_STAT, rd_val);   chk("ovr_stat_clear", rd_val, 32'h00);
        exp_q.push_back(8'h5A);
        run_xfer(8'h5A, 3);
        chk("ovr_first_busy", 32'(busy_n), 32'd18);
        chk("ovr_first_mosi", 32'(cap), 32'h5A);
        rd_reg(REG_STAT, rd_val);   chk("ovr_txovr", rd_val, 32'h0E);
        // 0x5A is never read: the next completion overwrites it
        void'(exp_q.pop_back());
        exp_q.push_back(8'hC3);
        run_xfer(8'hC3, -1);
        rd_reg(REG_STAT, rd_val);   chk("ovr_rxovr", rd_val, 32'h1E);
        check_rx("ovr_rxdata_second");
        wr_reg(REG_STAT, 32'h1A);
        rd_reg(REG_STAT, rd_val);   chk("ovr_w1c_all", rd_val, 32'h00);

        // Manual chip select across two bytes
        wr_reg(REG_CTRL, 32'h0000_0009);
        chk("man_cs_low", 32'(SPI0_CS), 32'd0);
        exp_q.push_back(8'h12);
        run_xfer(8'h12, -1);
        chk("man_cs_no_rise_1", 32'(cs_rises), 32'd0);
        check_rx("man_rx_1");
        exp_q.push_back(8'h34);
        run_xfer(8'h34, -1);
        chk("man_cs_no_rise_2", 32'(cs_rises), 32'd0);
        chk("man_mosi_2", 32'(cap), 32'h34);
        chk("man_cs_still_low", 32'(SPI0_CS), 32'd0);
        check_rx("man_rx_2");
        wr_reg(REG_CTRL, 32'h0000_0019);
        chk("man_cs_released", 32'(SPI0_CS), 32'd1);

        // Abort by clearing EN mid-transfer
        wr_reg(REG_CTRL, 32'h0000_0101);
        wr_reg(REG_STAT, 32'h1A);
        wr_reg(REG_TXDATA, 32'h81);
        repeat (5) @(negedge clk);
        chk("abort_cs_active", 32'(SPI0_CS), 32'd0);
        wr_reg(REG_CTRL, 32'h0000_0100);
        chk("abort_cs_high", 32'(SPI0_CS), 32'd1);
        chk("abort_sck_cpol", 32'(SPI0_SCK), 32'd0);
        rd_reg(REG_STAT, rd_val);   chk("abort_stat_now", rd_val, 32'h00);
        repeat (40) @(negedge clk);
        rd_reg(REG_STAT, rd_val);   chk("abort_stat_later", rd_val, 32'h00);

        // Reset in the middle of XFER
        wr_reg(REG_CTRL, 32'h0000_0321);
        wr_reg(REG_TXDATA, 32'hFF);
        repeat (10) @(negedge clk);
        raddr_i = REG_CTRL; rd_i = 1'b1;
        @(negedge clk);
        chk("rstx_pre_mosi", 32'(SPI0_MOSI), 32'd1);
        chk("rstx_pre_data_o", data_o, 32'h321);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstx_sck", 32'(SPI0_SCK), 32'd0);
        chk("rstx_cs", 32'(SPI0_CS), 32'd1);
        chk("rstx_mosi", 32'(SPI0_MOSI), 32'd0);
        chk("rstx_data_o", data_o, 32'd0);
        chk("rstx_irq", 32'(irq_spi0), 32'd0);
        rd_i = 1'b0; rst_n = 1'b1;
        rd_reg(REG_STAT, rd_val);   chk("rstx_stat", rd_val, 32'd0);
        rd_reg(REG_CTRL, rd_val);   chk("rstx_ctrl", rd_val, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
